// File: rtl/mat_scroll_if.sv
// -----------------------------------------------------------------------------
// mat_scroll_if
//   Host/scanner-facing signal bundle of the scrolling message feeder.
//
//   Host -> feeder : wr_en, wr_row, wr_chunk, wr_data, commit, run, dir
//   Feeder -> host : m0..m7 (16-column window rows), offset, busy, wrap
//
//   master : the host side (drives writes/commit/run/dir, observes window)
//   slave  : the mat_scroll block itself
// -----------------------------------------------------------------------------
interface mat_scroll_if #(
    parameter int COL_AW = 6
);
    logic              wr_en;
    logic [2:0]        wr_row;
    logic [COL_AW-5:0] wr_chunk;
    logic [15:0]       wr_data;
    logic              commit;
    logic              run;
    logic              dir;

    logic [15:0]       m0;
    logic [15:0]       m1;
    logic [15:0]       m2;
    logic [15:0]       m3;
    logic [15:0]       m4;
    logic [15:0]       m5;
    logic [15:0]       m6;
    logic [15:0]       m7;
    logic [COL_AW-1:0] offset;
    logic              busy;
    logic              wrap;

    modport master (
        output wr_en, wr_row, wr_chunk, wr_data, commit, run, dir,
        input  m0, m1, m2, m3, m4, m5, m6, m7, offset, busy, wrap
    );

    modport slave (
        input  wr_en, wr_row, wr_chunk, wr_data, commit, run, dir,
        output m0, m1, m2, m3, m4, m5, m6, m7, offset, busy, wrap
    );
endinterface

// File: rtl/mat_scroll.sv
// -----------------------------------------------------------------------------
// mat_scroll
//   Upstream feeder for the 8 x 16 LED matrix scanner. Holds a double-buffered
//   8 x MSG_W message bitmap (shadow bank written by the host in 16-bit chunks,
//   active bank shown on the matrix) and presents a 16-column circular window
//   of the active bank, scrolling one column every STEP_DIV clocks.
//
//   Ports:
//     clock  : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : mat_scroll_if.slave
//              wr_en/wr_row/wr_chunk/wr_data : shadow bank chunk write
//              commit : request shadow -> active copy (tear-free)
//              run    : 1 = scrolling, 0 = frozen
//              dir    : 0 = left (offset++), 1 = right (offset--)
//              m0..m7 : registered window rows, bit j = col (offset+j) mod MSG_W
//              offset : window start column
//              busy   : commit pending
//              wrap   : one-cycle pulse when a scroll step lands on offset 0
// -----------------------------------------------------------------------------
module mat_scroll #(
    parameter int MSG_W    = 64,
    parameter int COL_AW   = 6,
    parameter int STEP_DIV = 2500000
) (
    input  logic        clock,
    input  logic        rst_n,
    mat_scroll_if.slave bus
);
    localparam int            TW    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [TW-1:0] TLAST = TW'(STEP_DIV - 1);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [COL_AW-1:0] offset_q, offset_d;
    logic              wrap_q, wrap_d;
    logic [MSG_W-1:0]  shadow_q [8];
    logic [MSG_W-1:0]  shadow_d [8];
    logic [MSG_W-1:0]  active_q [8];
    logic [MSG_W-1:0]  active_d [8];
    logic [15:0]       m_q [8];
    logic [15:0]       m_d [8];
    logic              tick;
    logic              apply;

    assign tick = bus.run && (timer_q == TLAST);

    // Step timer: free-runs only while scrolling, parked at 0 otherwise so the
    // first tick after run rises is a full STEP_DIV clocks away.
    always_comb begin
        timer_d = '0;
        if (bus.run) begin
            timer_d = (timer_q == TLAST) ? '0 : timer_q + 1'b1;
        end
    end

    // Commit FSM: a pending copy waits for a step boundary while scrolling so
    // the window never shows a half-old/half-new message.
    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.commit) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!bus.run || tick) begin
                    apply   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow next-state carries the current write so an apply in the same
    // cycle copies the merged value.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            shadow_d[r] = shadow_q[r];
            active_d[r] = apply ? shadow_d[r] : active_q[r];
        end
        if (bus.wr_en) begin
            shadow_d[bus.wr_row][{bus.wr_chunk, 4'b0000} +: 16] = bus.wr_data;
            if (apply) begin
                active_d[bus.wr_row] = shadow_d[bus.wr_row];
            end
        end
    end

    // Offset: an apply replaces the scroll step and never reports a wrap.
    always_comb begin
        offset_d = offset_q;
        wrap_d   = 1'b0;
        if (apply) begin
            offset_d = '0;
        end else if (tick) begin
            offset_d = bus.dir ? offset_q - 1'b1 : offset_q + 1'b1;
            wrap_d   = (offset_d == '0);
        end
    end

    // Circular window: the COL_AW-bit index sum wraps modulo MSG_W.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            m_d[r] = '0;
            for (int j = 0; j < 16; j++) begin
                m_d[r][j] = active_q[r][COL_AW'(offset_q + COL_AW'(j))];
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            offset_q <= '0;
            wrap_q   <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                shadow_q[r] <= '0;
                active_q[r] <= '0;
                m_q[r]      <= '0;
            end
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            offset_q <= offset_d;
            wrap_q   <= wrap_d;
            for (int r = 0; r < 8; r++) begin
                shadow_q[r] <= shadow_d[r];
                active_q[r] <= active_d[r];
                m_q[r]      <= m_d[r];
            end
        end
    end

    assign bus.m0     = m_q[0];
    assign bus.m1     = m_q[1];
    assign bus.m2     = m_q[2];
    assign bus.m3     = m_q[3];
    assign bus.m4     = m_q[4];
    assign bus.m5     = m_q[5];
    assign bus.m6     = m_q[6];
    assign bus.m7     = m_q[7];
    assign bus.offset = offset_q;
    assign bus.busy   = (state_q == ST_PEND);
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_mat_scroll.sv
// -----------------------------------------------------------------------------
// tb_mat_scroll
//   Directed bench for mat_scroll with MSG_W=32, COL_AW=5, STEP_DIV=4.
//   Row 0 holds columns 0 and 31 set, so window values around the circular
//   seam are easy to hand-compute.
// -----------------------------------------------------------------------------
module tb_mat_scroll;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mat_scroll_if #(.COL_AW(5)) bus ();

    mat_scroll #(
        .MSG_W    (32),
        .COL_AW   (5),
        .STEP_DIV (4)
    ) dut (
        .clock (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [127:0] win();
        return {bus.m7, bus.m6, bus.m5, bus.m4, bus.m3, bus.m2, bus.m1, bus.m0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_row   = 3'd0;
        bus.wr_chunk = 1'b0;
        bus.wr_data  = 16'h0000;
        bus.commit   = 1'b0;
        bus.run      = 1'b0;
        bus.dir      = 1'b0;

        // Reset held, then released away from the clock edge
        clks(2);
        chk("rst_win", win(), 128'h0);
        chk("rst_off", 128'(bus.offset), 128'h0);
        chk("rst_busy", 128'(bus.busy), 128'h0);
        chk("rst_wrap", 128'(bus.wrap), 128'h0);
        rst_n = 1'b1;

        // Idle 20 clocks with run=0
        for (int i = 0; i < 20; i++) begin
            clks(1);
            chk("idle_win", win(), 128'h0);
            chk("idle_stat", 128'({bus.offset, bus.busy, bus.wrap}), 128'h0);
        end

        // Load row 0: col 0 and col 31, then commit with run=0
        bus.wr_en    = 1'b1;
        bus.wr_row   = 3'd0;
        bus.wr_chunk = 1'b0;
        bus.wr_data  = 16'h0001;
        clks(1);
        bus.wr_chunk = 1'b1;
        bus.wr_data  = 16'h8000;
        clks(1);
        bus.wr_en    = 1'b0;
        bus.commit   = 1'b1;
        clks(1);
        bus.commit   = 1'b0;
        chk("c0_busy", 128'(bus.busy), 128'h1);
        chk("c0_win_old", win(), 128'h0);
        clks(1);
        chk("c0_applied_busy", 128'(bus.busy), 128'h0);
        chk("c0_win_lat", win(), 128'h0);
        clks(1);
        chk("c0_win", win(), 128'h0001);
        chk("c0_off", 128'(bus.offset), 128'h0);

        // Scroll left: offset = floor(k/4), window one clock behind
        bus.run = 1'b1;
        bus.dir = 1'b0;
        clks(4);
        chk("k4_off", 128'(bus.offset), 128'd1);
        clks(1);
        chk("k5_win", win(), 128'h0000);
        clks(63);
        chk("k68_off", 128'(bus.offset), 128'd17);
        clks(1);
        chk("k69_win", win(), 128'hC000);
        clks(55);
        chk("k124_off", 128'(bus.offset), 128'd31);
        clks(1);
        chk("k125_win", win(), 128'h0003);
        clks(2);
        chk("k127_wrap", 128'(bus.wrap), 128'h0);
        chk("k127_off", 128'(bus.offset), 128'd31);
        clks(1);
        chk("k128_wrap", 128'(bus.wrap), 128'h1);
        chk("k128_off", 128'(bus.offset), 128'd0);
        clks(1);
        chk("k129_wrap", 128'(bus.wrap), 128'h0);
        chk("k129_win", win(), 128'h0001);

        // Scroll right from offset 0
        bus.dir = 1'b1;
        clks(3);
        chk("r_off", 128'(bus.offset), 128'd31);
        chk("r_wrap", 128'(bus.wrap), 128'h0);
        clks(1);
        chk("r_win", win(), 128'h0003);
        chk("r_wrap2", 128'(bus.wrap), 128'h0);

        // Mid-count commit while scrolling: waits for the tick at k=136
        bus.wr_en    = 1'b1;
        bus.wr_row   = 3'd7;
        bus.wr_chunk = 1'b0;
        bus.wr_data  = 16'hFFFF;
        bus.commit   = 1'b1;
        clks(1);
        bus.wr_en    = 1'b0;
        bus.commit   = 1'b0;
        chk("s5_busy_a", 128'(bus.busy), 128'h1);
        chk("s5_off_a", 128'(bus.offset), 128'd31);
        clks(1);
        chk("s5_busy_b", 128'(bus.busy), 128'h1);
        chk("s5_off_b", 128'(bus.offset), 128'd31);
        clks(1);
        chk("s5_tick_off", 128'(bus.offset), 128'd0);
        chk("s5_tick_busy", 128'(bus.busy), 128'h0);
        chk("s5_tick_wrap", 128'(bus.wrap), 128'h0);
        chk("s5_tick_win", win(), 128'h0003);
        clks(1);
        chk("s5_win", win(), {16'hFFFF, 96'h0, 16'h0001});
        chk("s5_wrap", 128'(bus.wrap), 128'h0);

        // Scroll left to offset 5, raise a commit, then reset mid-operation
        bus.dir = 1'b0;
        clks(20);
        chk("s6_off5", 128'(bus.offset), 128'd5);
        bus.commit = 1'b1;
        clks(1);
        bus.commit = 1'b0;
        chk("s6_busy", 128'(bus.busy), 128'h1);
        chk("s6_win_pre", win(), {16'h07FF, 112'h0});
        #2;
        rst_n   = 1'b0;
        bus.run = 1'b0;
        #1;
        chk("s6_async_win", win(), 128'h0);
        chk("s6_async_stat", 128'({bus.offset, bus.busy, bus.wrap}), 128'h0);
        clks(2);
        rst_n = 1'b1;
        clks(2);
        chk("s6_discard_busy", 128'(bus.busy), 128'h0);
        chk("s6_rel_off", 128'(bus.offset), 128'h0);
        bus.commit = 1'b1;
        clks(1);
        bus.commit = 1'b0;
        chk("s6_c_busy", 128'(bus.busy), 128'h1);
        clks(1);
        chk("s6_c_done", 128'(bus.busy), 128'h0);
        clks(1);
        chk("s6_zero_win", win(), 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
